// File: rtl/pulse_stretch_pkg.sv
// pulse_stretch_pkg
// Shared definitions for the pulse stretcher: FSM state encodings.
// Encoding 2'd3 is unused; the FSM treats it as illegal and falls back
// to IDLE on the next clock edge.
package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/sat_updown_cnt.sv
// sat_updown_cnt
// Saturating up/down counter with a registered drop strobe.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   inc      - request to count up
//   dec      - request to count down (never below zero)
//   count    - current count
//   sat_drop - one-cycle strobe: an increment was lost at saturation
module sat_updown_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         sat_drop
);

    localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_r;
    logic         sat_drop_r;

    // Count update; a simultaneous inc and dec cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r    <= CNT_ZERO;
            sat_drop_r <= 1'b0;
        end else begin
            sat_drop_r <= 1'b0;
            case ({inc, dec})
                2'b10: begin
                    if (count_r == CNT_MAX) begin
                        sat_drop_r <= 1'b1;
                    end else begin
                        count_r <= count_r + CNT_ONE;
                    end
                end
                2'b01: begin
                    if (count_r != CNT_ZERO) begin
                        count_r <= count_r - CNT_ONE;
                    end else begin
                        count_r <= count_r;
                    end
                end
                default: count_r <= count_r;
            endcase
        end
    end

    assign count    = count_r;
    assign sat_drop = sat_drop_r;

endmodule

// File: rtl/pulse_stretch.sv
// pulse_stretch
// Turns one-cycle event pulses into fixed-width high windows separated by
// a forced low gap. Events arriving during a window or gap are queued in a
// saturating counter and replayed in order.
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   pulse_in  - event strobe, each high cycle is one event
//   level_out - registered stretched output
//   busy      - high whenever the FSM is not IDLE
//   pending   - number of queued events not yet played
//   overflow  - registered one-cycle strobe: an event was dropped
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int ON_CYCLES  = 255,
    parameter int OFF_CYCLES = 255,
    parameter int TIMER_W    = 8,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    output logic             level_out,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    localparam logic [TIMER_W-1:0] ON_LOAD    = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OFF_LOAD   = TIMER_W'(OFF_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ZERO = {TIMER_W{1'b0}};
    localparam logic [TIMER_W-1:0] TIMER_ONE  = {{(TIMER_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   PEND_ZERO  = {CNT_W{1'b0}};

    state_t             state_r;
    logic [TIMER_W-1:0] timer_r;
    logic               level_r;

    logic               gap_exit_s;
    logic               queue_nonempty_s;
    logic               direct_s;
    logic               inc_s;
    logic               dec_s;
    logic [CNT_W-1:0]   pending_s;

    // Event routing: a pulse either starts a window directly (from IDLE, or
    // at GAP exit with an empty queue) or is queued. At GAP exit with a
    // non-empty queue the oldest queued event is played first.
    always_comb begin
        gap_exit_s       = 1'b0;
        queue_nonempty_s = 1'b0;
        direct_s         = 1'b0;
        inc_s            = 1'b0;
        dec_s            = 1'b0;
        queue_nonempty_s = (pending_s != PEND_ZERO);
        gap_exit_s       = (state_r == GAP) && (timer_r == TIMER_ZERO);
        if (state_r == IDLE) begin
            direct_s = pulse_in;
        end else if (gap_exit_s && !queue_nonempty_s) begin
            direct_s = pulse_in;
        end else begin
            direct_s = 1'b0;
        end
        dec_s = gap_exit_s && queue_nonempty_s;
        // Only ON and GAP may queue, so pending stays zero outside a run.
        inc_s = pulse_in && !direct_s && ((state_r == ON) || (state_r == GAP));
    end

    sat_updown_cnt #(
        .W(CNT_W)
    ) u_pending (
        .clk      (clk),
        .rst      (rst),
        .inc      (inc_s),
        .dec      (dec_s),
        .count    (pending_s),
        .sat_drop (overflow)
    );

    // Window FSM with down-counting timer; level_out is registered
    // alongside the state so it tracks state == ON exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            timer_r <= TIMER_ZERO;
            level_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pulse_in) begin
                        state_r <= ON;
                        timer_r <= ON_LOAD;
                        level_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        timer_r <= TIMER_ZERO;
                        level_r <= 1'b0;
                    end
                end
                ON: begin
                    if (timer_r == TIMER_ZERO) begin
                        state_r <= GAP;
                        timer_r <= OFF_LOAD;
                        level_r <= 1'b0;
                    end else begin
                        timer_r <= timer_r - TIMER_ONE;
                        level_r <= 1'b1;
                    end
                end
                GAP: begin
                    if (timer_r != TIMER_ZERO) begin
                        timer_r <= timer_r - TIMER_ONE;
                        level_r <= 1'b0;
                    end else if (queue_nonempty_s || pulse_in) begin
                        state_r <= ON;
                        timer_r <= ON_LOAD;
                        level_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        timer_r <= TIMER_ZERO;
                        level_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    timer_r <= TIMER_ZERO;
                    level_r <= 1'b0;
                end
            endcase
        end
    end

    assign level_out = level_r;
    assign busy      = (state_r != IDLE);
    assign pending   = pending_s;

endmodule
